// File: rtl/rasterizer_frame_buffer_if.sv
// Pixel write and display read bus between the rasterizer, the frame buffer and scan-out.
// The master modport is the rasterizer/display side; slave is the frame buffer.
interface rasterizer_frame_buffer_if #(
   parameter int VERT_RESOLUTION  = 60,
   parameter int HORIZ_RESOLUTION = 80
);
   localparam int AW_V = $clog2(VERT_RESOLUTION);
   localparam int AW_H = $clog2(HORIZ_RESOLUTION);

   logic            i_write_en;
   logic [AW_V-1:0] i_vert_write_addr;
   logic [AW_H-1:0] i_horiz_write_addr;
   logic [3:0]      i_red;
   logic [3:0]      i_green;
   logic [3:0]      i_blue;
   logic            i_frame_done;
   logic            i_vblank;
   logic            i_read_en;
   logic [AW_V-1:0] i_vert_read_addr;
   logic [AW_H-1:0] i_horiz_read_addr;
   logic [3:0]      o_red;
   logic [3:0]      o_green;
   logic [3:0]      o_blue;
   logic            o_read_valid;
   logic            o_ready;
   logic            o_swap_pending;
   logic            o_front_bank;
   logic [7:0]      o_swap_count;

   modport master (
      output i_write_en, i_vert_write_addr, i_horiz_write_addr, i_red, i_green, i_blue,
      output i_frame_done, i_vblank, i_read_en, i_vert_read_addr, i_horiz_read_addr,
      input  o_red, o_green, o_blue, o_read_valid, o_ready, o_swap_pending,
      input  o_front_bank, o_swap_count
   );

   modport slave (
      input  i_write_en, i_vert_write_addr, i_horiz_write_addr, i_red, i_green, i_blue,
      input  i_frame_done, i_vblank, i_read_en, i_vert_read_addr, i_horiz_read_addr,
      output o_red, o_green, o_blue, o_read_valid, o_ready, o_swap_pending,
      output o_front_bank, o_swap_count
   );
endinterface

// File: rtl/rasterizer_frame_buffer.sv
// Double-buffered 12-bit RGB frame store; banks swap on the first vblank after frame done.
// RASTERIZER_FB_TRANSPARENT_BLACK_EN: drop black writes and clear the back bank after reset/swap.
module rasterizer_frame_buffer #(
   parameter int VERT_RESOLUTION  = 60,
   parameter int HORIZ_RESOLUTION = 80
) (
   input logic                      i_clk,
   input logic                      i_arst_n,
   rasterizer_frame_buffer_if.slave fb
);
   localparam int AW_V = $clog2(VERT_RESOLUTION);
   localparam int AW_H = $clog2(HORIZ_RESOLUTION);
   localparam int PIX  = VERT_RESOLUTION * HORIZ_RESOLUTION;
   localparam int IW   = $clog2(2 * PIX);

`ifdef RASTERIZER_FB_TRANSPARENT_BLACK_EN
   localparam int CW = $clog2(PIX);
   typedef enum logic [1:0] {RENDER = 2'd0, SWAP_WAIT = 2'd1, CLEAR = 2'd2} state_t;
   logic [CW-1:0] clr_idx_r;
`else
   typedef enum logic [1:0] {RENDER = 2'd0, SWAP_WAIT = 2'd1} state_t;
`endif

   state_t        state_r;
   logic          ready_r;
   logic          pending_r;
   logic          front_r;
   logic [7:0]    count_r;
   logic [11:0]   colour_r;
   logic          valid_r;
   logic [11:0]   mem_r [0:2*PIX-1];

   logic          wr_en_s;
   logic [IW-1:0] wr_idx_s;
   logic [11:0]   wr_data_s;
   logic [11:0]   wr_colour_s;
   logic          wr_keep_s;
   logic          rd_in_range_s;
   logic [IW-1:0] rd_idx_s;

   function automatic logic [IW-1:0] pix_index(input logic bank, input logic [AW_V-1:0] y,
                                               input logic [AW_H-1:0] x);
      return IW'(bank) * IW'(PIX) + IW'(y) * IW'(HORIZ_RESOLUTION) + IW'(x);
   endfunction

   function automatic logic in_range(input logic [AW_V-1:0] y, input logic [AW_H-1:0] x);
      return (int'(x) < HORIZ_RESOLUTION) && (int'(y) < VERT_RESOLUTION);
   endfunction

   assign wr_colour_s = {fb.i_red, fb.i_green, fb.i_blue};
`ifdef RASTERIZER_FB_TRANSPARENT_BLACK_EN
   assign wr_keep_s = (wr_colour_s != 12'd0);
`else
   assign wr_keep_s = 1'b1;
`endif

   // Single memory write port: rasterizer pixels in RENDER, zero fill in CLEAR.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = '0;
      wr_data_s = 12'd0;
      case (state_r)
         RENDER: begin
            if (fb.i_write_en && wr_keep_s &&
                in_range(fb.i_vert_write_addr, fb.i_horiz_write_addr)) begin
               wr_en_s   = 1'b1;
               wr_idx_s  = pix_index(~front_r, fb.i_vert_write_addr, fb.i_horiz_write_addr);
               wr_data_s = wr_colour_s;
            end else begin
               wr_en_s = 1'b0;
            end
         end
`ifdef RASTERIZER_FB_TRANSPARENT_BLACK_EN
         CLEAR: begin
            wr_en_s   = 1'b1;
            wr_idx_s  = IW'(~front_r) * IW'(PIX) + IW'(clr_idx_r);
            wr_data_s = 12'd0;
         end
`endif
         default: wr_en_s = 1'b0;
      endcase
   end

   // Read address always targets the displayed bank.
   always_comb begin
      rd_in_range_s = in_range(fb.i_vert_read_addr, fb.i_horiz_read_addr);
      rd_idx_s      = pix_index(front_r, fb.i_vert_read_addr, fb.i_horiz_read_addr);
   end

   // Pixel storage, intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   // Bank control FSM with registered status outputs.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
`ifdef RASTERIZER_FB_TRANSPARENT_BLACK_EN
         state_r   <= CLEAR;
         ready_r   <= 1'b0;
         clr_idx_r <= '0;
`else
         state_r   <= RENDER;
         ready_r   <= 1'b1;
`endif
         pending_r <= 1'b0;
         front_r   <= 1'b0;
         count_r   <= 8'd0;
      end else begin
         case (state_r)
            RENDER: begin
               if (fb.i_frame_done) begin
                  state_r   <= SWAP_WAIT;
                  ready_r   <= 1'b0;
                  pending_r <= 1'b1;
               end else begin
                  ready_r   <= 1'b1;
                  pending_r <= 1'b0;
               end
            end
            SWAP_WAIT: begin
               if (fb.i_vblank) begin
                  front_r   <= ~front_r;
                  count_r   <= count_r + 8'd1;
                  pending_r <= 1'b0;
`ifdef RASTERIZER_FB_TRANSPARENT_BLACK_EN
                  state_r   <= CLEAR;
                  ready_r   <= 1'b0;
                  clr_idx_r <= '0;
`else
                  state_r   <= RENDER;
                  ready_r   <= 1'b1;
`endif
               end else begin
                  ready_r   <= 1'b0;
                  pending_r <= 1'b1;
               end
            end
`ifdef RASTERIZER_FB_TRANSPARENT_BLACK_EN
            CLEAR: begin
               if (clr_idx_r == CW'(PIX - 1)) begin
                  state_r   <= RENDER;
                  ready_r   <= 1'b1;
                  clr_idx_r <= '0;
               end else begin
                  clr_idx_r <= clr_idx_r + CW'(1);
               end
            end
`endif
            default: begin
               state_r   <= RENDER;
               ready_r   <= 1'b1;
               pending_r <= 1'b0;
            end
         endcase
      end
   end

   // One-cycle read pipeline; colour holds between reads.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         colour_r <= 12'd0;
         valid_r  <= 1'b0;
      end else if (fb.i_read_en) begin
         colour_r <= rd_in_range_s ? mem_r[rd_idx_s] : 12'd0;
         valid_r  <= 1'b1;
      end else begin
         valid_r  <= 1'b0;
      end
   end

   assign fb.o_red          = colour_r[11:8];
   assign fb.o_green        = colour_r[7:4];
   assign fb.o_blue         = colour_r[3:0];
   assign fb.o_read_valid   = valid_r;
   assign fb.o_ready        = ready_r;
   assign fb.o_swap_pending = pending_r;
   assign fb.o_front_bank   = front_r;
   assign fb.o_swap_count   = count_r;
endmodule

// File: doc/rasterizer_frame_buffer.md
# rasterizer_frame_buffer

Double-buffered 12-bit RGB pixel store sitting directly downstream of the rasterizer. Accepts the rasterizer's per-pixel write stream (address, colour, write enable, done) into the back bank while the display scan-out reads the front bank. The banks swap at the first vertical-blank pulse after a frame is marked done.

## Interface
- VERT_RESOLUTION, 60, frame height in pixels
- HORIZ_RESOLUTION, 80, frame width in pixels
- Widths: AW_V = $clog2(VERT_RESOLUTION), AW_H = $clog2(HORIZ_RESOLUTION)

- i_clk  in  1  clock; all logic rising-edge
- i_arst_n  in  1  reset; asynchronous, active-low
- i_write_en  in  1  pixel write strobe (rasterizer o_write_en)
- i_vert_write_addr  in  AW_V  write row
- i_horiz_write_addr  in  AW_H  write column
- i_red / i_green / i_blue  in  4 each  write colour
- i_frame_done  in  1  single-cycle pulse: back-bank frame complete (rasterizer o_done)
- i_vblank  in  1  single-cycle pulse at start of display vertical blanking
- i_read_en  in  1  display read strobe
- i_vert_read_addr  in  AW_V  read row
- i_horiz_read_addr  in  AW_H  read column
- o_red / o_green / o_blue  out  4 each  read colour
- o_read_valid  out  1  read data valid
- o_ready  out  1  back bank accepts a new frame
- o_swap_pending  out  1  frame done, waiting for vblank
- o_front_bank  out  1  bank currently displayed
- o_swap_count  out  8  completed swaps, wraps 255→0

## Operation
- Storage: 2·V·H words × 12 bits ({r,g,b}); index = bank·V·H + y·H + x. Back bank = ~o_front_bank.
- FSM states: RENDER, SWAP_WAIT, CLEAR (CLEAR exists only with macro).
- RENDER: o_ready=1; i_write_en with in-range address writes back bank; out-of-range (x≥H or y≥V) dropped. i_frame_done → SWAP_WAIT (write in the same cycle is still accepted).
- SWAP_WAIT: o_ready=0, o_swap_pending=1; writes ignored. i_vblank → toggle o_front_bank, o_swap_count+1, → CLEAR (macro) or RENDER.
- CLEAR: writes 0 to every back-bank location, one per cycle, index 0..V·H−1, then → RENDER. i_write_en and i_frame_done ignored.
- i_frame_done outside RENDER ignored. i_vblank outside SWAP_WAIT ignored; i_vblank coincident with i_frame_done in RENDER does not swap (next vblank does).
- Reads always served from front bank; out-of-range read returns 0 with o_read_valid=1.

## Timing
- Write: stored at the clock edge where i_write_en is sampled; readable from the front bank only after swap.
- Read latency 1: o_read_valid and colour valid the cycle after i_read_en; o_read_valid=0 otherwise, colour holds last value.
- Swap: o_front_bank changes the cycle after the i_vblank sample; a read issued in the vblank cycle uses the old bank.
- CLEAR duration exactly V·H cycles (4800 at default); o_ready rises the cycle after the last clear write.
- Reset values: o_red/o_green/o_blue=0, o_read_valid=0, o_swap_pending=0, o_front_bank=0, o_swap_count=0, o_ready=1 without macro / 0 with macro. State after reset: RENDER without macro; CLEAR of bank 1 from index 0 with macro. Reset mid-clear restarts from index 0. Memory contents are not reset.

## Configuration
- RASTERIZER_FB_TRANSPARENT_BLACK_EN defined: writes with r=g=b=0 are suppressed (black treated as transparent), enabling multiple triangles composited per frame; CLEAR state active after reset and after every swap.
- Undefined: every write stored including black; no CLEAR state; back bank returns to RENDER immediately after swap.

## Test plan
- Write (x=5,y=3,rgb=F/0/A), i_frame_done, i_vblank, read (5,3) → o_front_bank=1, next-cycle read data F/0/A, o_swap_count=1.
- Write during SWAP_WAIT to (1,1)=0x111 then swap, read (1,1) → value from before SWAP_WAIT, not 0x111.
- i_frame_done and i_vblank same cycle → no swap; swap on the following i_vblank pulse only.
- Out-of-range write x=80 → nothing stored; read x=80,y=0 → 0 with o_read_valid=1.
- Macro on: write black over (2,2)=0xABC → 0xABC retained; after swap, o_ready low exactly 4800 cycles, new back bank reads all 0 after next swap.
- Assert i_arst_n low mid-CLEAR at index 1000 → all outputs to reset values, clear restarts at 0, o_ready rises 4800 cycles after release.
